// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with first-word fall-through receive FIFO

module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    data,
  output logic                          valid,
  input  logic                          ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam int          PW           = $clog2(FIFO_DEPTH);
  localparam int          CW           = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, pop, wr_en;

`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_q, parity_err_d;
`endif

  // Receive framing FSM plus FIFO bookkeeping; frame errors take precedence over parity errors.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 16'd0;
          idx_d = 3'd0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = 16'd0;
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (rx_s_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           push = 1'b1;
`else
            push = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    full      = (count_q == CW'(FIFO_DEPTH));
    pop       = valid && ready;
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(wr_en) - CW'(pop);
  end

  // Synchronizer, FSM state and FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because valid gates the output.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign valid      = (count_q != '0);
  assign data       = valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous UART line, idle high, 8 data bits LSB first.
REQ-007 SHALL have port data  output  8  FIFO head byte, valid only while valid=1.
REQ-008 SHALL have port valid  output  1  FIFO not empty.
REQ-009 SHALL have port ready  input  1  consumer accepts the head byte when valid && ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held, 0..FIFO_DEPTH.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); adds 2 cycles latency.
REQ-014 SHALL implement states IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH with a 16-bit bit-period counter and a 3-bit bit index.
REQ-015 IDLE: rx_s==0 -> START, counter=0.
REQ-016 START: at counter==CLKS_PER_BIT/2-1, sample rx_s; 0 -> DATA, counter=0, index=0; 1 -> IDLE (glitch rejected, no error pulse).
REQ-017 DATA: at counter==CLKS_PER_BIT-1, shift rx_s into bit[index], counter=0; after index 7 -> STOP (or PARITY, REQ-030).
REQ-018 STOP: at counter==CLKS_PER_BIT-1, sample rx_s; 1 -> push byte, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rx_s==1, then IDLE (break condition yields exactly one frame_err).
REQ-020 Push: byte SHALL appear on data/valid the cycle after the stop-bit sample cycle (first-word fall-through).
REQ-021 Pop SHALL occur on every cycle with valid && ready; data SHALL show the next entry in the following cycle; ready with valid=0 has no effect.
REQ-022 Push when full with no pop in the same cycle SHALL drop the byte, pulse overrun, and leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when full; fifo_count unchanged.
REQ-024 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; fifo_count is tracked separately.
REQ-025 frame_err and overrun SHALL be single-cycle pulses, never both set by one frame.

Reset
REQ-026 On rst: state=IDLE, synchronizer flops=1, counters/index=0, FIFO pointers and fifo_count=0, valid=0, frame_err=0, overrun=0, data=0.
REQ-027 rst mid-frame SHALL abandon the frame with no push and no error pulse; a line still low after reset release SHALL be treated as a new start edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN SHALL select the frame format.
REQ-029 Without UART_RX_PARITY_EN: 8N1; PARITY state absent; no parity_err port.
REQ-030 With UART_RX_PARITY_EN: 8E1; DATA -> PARITY; PARITY samples one bit at CLKS_PER_BIT-1; added port parity_err output 1 pulses when data XOR parity bit != 0; the byte is discarded; the stop bit is still checked, and a frame with both errors pulses frame_err only.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-031 Send 0xA5 8N1, ready=1 -> one valid cycle with data=0xA5, fifo_count returns to 0, no error pulses.
REQ-032 Pull rx low 3 cycles, then high -> no push, no errors, state returns to IDLE.
REQ-033 Send 0x3C with the stop bit held low, then hold the line low 50 cycles -> one frame_err pulse, fifo_count=0, next good byte 0x11 is received correctly.
REQ-034 ready=0, send 0x01..0x05 -> fifo_count=4, one overrun pulse on the 5th byte; then ready=1 -> pops 0x01,0x02,0x03,0x04 in order.
REQ-035 FIFO full, assert ready in the push cycle of a 5th byte 0x77 -> no overrun, fifo_count stays 4, 0x77 is the last byte popped.
REQ-036 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> one parity_err pulse, no push; with parity bit 1 -> data=0x07.
